// File: rtl/pixel_fb_writer.sv
// Pixel stream to framebuffer writer: clips, queues and converts pixels to RGB565,
// writes them over a req/ack port, and performs full-screen clears and flush notification.
module pixel_fb_writer #(
    parameter int FB_W       = 160,
    parameter int FB_H       = 120,
    parameter int ADDR_W     = 15,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pixel_valid,
    input  logic [7:0]        px,
    input  logic [7:0]        py,
    input  logic [23:0]       pixel_color,
    input  logic              shape_done,
    input  logic              clear_start,
    input  logic [23:0]       clear_color,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic              mem_ack,
    output logic              busy,
    output logic              flush_done,
    output logic              overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_CLEAR = 2'd2;

    localparam logic [8:0]        FB_W9     = 9'(FB_W);
    localparam logic [8:0]        FB_H9     = 9'(FB_H);
    localparam logic [ADDR_W-1:0] FB_W_A    = ADDR_W'(FB_W);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_W * FB_H - 1);
    localparam logic [PTR_W:0]    DEPTH_C   = (PTR_W + 1)'(FIFO_DEPTH);

    logic [1:0]        state;
    logic              shape_done_q;
    logic              clear_start_q;
    logic              clear_pend;
    logic              flush_pend;
    logic [15:0]       clear_rgb;

    logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
    logic [15:0]       fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count;

    logic              in_range;
    logic              fifo_empty;
    logic              fifo_full;
    logic              push;
    logic              pop;
    logic              shape_edge;
    logic              clear_edge;
    logic [ADDR_W-1:0] pix_addr;
    logic [15:0]       pix_rgb;
    logic [15:0]       clr_rgb;
    logic              unused_color_bits;

    assign pix_rgb = {pixel_color[23:19], pixel_color[15:10], pixel_color[7:3]};
    assign clr_rgb = {clear_color[23:19], clear_color[15:10], clear_color[7:3]};
    assign unused_color_bits = ^{pixel_color[18:16], pixel_color[9:8], pixel_color[2:0],
                                 clear_color[18:16], clear_color[9:8], clear_color[2:0]};

    assign in_range   = pixel_valid && ({1'b0, px} < FB_W9) && ({1'b0, py} < FB_H9);
    assign pix_addr   = ADDR_W'(py) * FB_W_A + ADDR_W'(px);
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == DEPTH_C);

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push then.
    assign pop  = !fifo_empty &&
                  ((state == ST_IDLE) || (state == ST_WRITE && mem_ack && !clear_pend));
    assign push = in_range && (!fifo_full || pop);

    assign shape_edge = shape_done && !shape_done_q;
    assign clear_edge = clear_start && !clear_start_q;

    assign busy       = (state != ST_IDLE) || !fifo_empty || clear_pend;
    assign flush_done = flush_pend && fifo_empty && (state == ST_IDLE) && !clear_pend;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= pix_addr;
            fifo_data[wr_ptr] <= pix_rgb;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            overflow      <= 1'b0;
            clear_pend    <= 1'b0;
            clear_rgb     <= '0;
            flush_pend    <= 1'b0;
            shape_done_q  <= 1'b0;
            clear_start_q <= 1'b0;
        end else begin
            shape_done_q  <= shape_done;
            clear_start_q <= clear_start;

            if (in_range && fifo_full && !pop) overflow <= 1'b1;

            if (flush_done) flush_pend <= 1'b0;
            if (shape_edge) flush_pend <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (clear_pend && fifo_empty) begin
                        state      <= ST_CLEAR;
                        clear_pend <= 1'b0;
                        overflow   <= 1'b0;
                        mem_we     <= 1'b1;
                        mem_addr   <= '0;
                        mem_wdata  <= clear_rgb;
                    end else if (!fifo_empty) begin
                        state     <= ST_WRITE;
                        mem_we    <= 1'b1;
                        mem_addr  <= fifo_addr[rd_ptr];
                        mem_wdata <= fifo_data[rd_ptr];
                    end
                end
                ST_WRITE: begin
                    if (mem_ack) begin
                        if (pop) begin
                            mem_addr  <= fifo_addr[rd_ptr];
                            mem_wdata <= fifo_data[rd_ptr];
                        end else begin
                            mem_we <= 1'b0;
                            state  <= ST_IDLE;
                        end
                    end
                end
                ST_CLEAR: begin
                    if (mem_ack) begin
                        if (mem_addr == LAST_ADDR) begin
                            mem_we <= 1'b0;
                            state  <= ST_IDLE;
                        end else begin
                            mem_addr <= mem_addr + 1'b1;
                        end
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    mem_we <= 1'b0;
                end
            endcase

            // Placed after the state case so a new request wins over the entry-to-clear reset.
            if (clear_edge && state != ST_CLEAR) begin
                clear_pend <= 1'b1;
                clear_rgb  <= clr_rgb;
            end
        end
    end

endmodule

// File: tb/tb_pixel_fb_writer.sv
// Directed testbench for pixel_fb_writer: table of single-pixel vectors plus
// hand-written sequences for bursts, overflow, flush, clear and reset.
module tb_pixel_fb_writer;

    logic        clk;
    logic        rst_n;
    logic        pixel_valid;
    logic [7:0]  px;
    logic [7:0]  py;
    logic [23:0] pixel_color;
    logic        shape_done;
    logic        clear_start;
    logic [23:0] clear_color;
    logic        mem_we;
    logic [14:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ack;
    logic        busy;
    logic        flush_done;
    logic        overflow;

    pixel_fb_writer #(
        .FB_W(160), .FB_H(120), .ADDR_W(15), .FIFO_DEPTH(8)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .pixel_valid(pixel_valid), .px(px), .py(py), .pixel_color(pixel_color),
        .shape_done(shape_done), .clear_start(clear_start), .clear_color(clear_color),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .busy(busy), .flush_done(flush_done), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [14:0] addr;
        logic [15:0] data;
        int          cyc;
    } wr_t;

    typedef struct {
        logic        valid;
        logic [7:0]  x;
        logic [7:0]  y;
        logic [23:0] color;
        logic        exp_write;
        logic [14:0] exp_addr;
        logic [15:0] exp_data;
    } vec_t;

    wr_t  wlog[$];
    vec_t vecs[10];
    int   cyc = 0;
    int   pulses = 0;
    int   pulse_cyc = -1;
    int   checks = 0;
    int   failures = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Accepted writes and flush pulses are captured mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (mem_we && mem_ack) wlog.push_back('{addr: mem_addr, data: mem_wdata, cyc: cyc});
        if (flush_done) begin
            pulses    = pulses + 1;
            pulse_cyc = cyc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input logic v, input logic [7:0] x, input logic [7:0] y,
                                  input logic [23:0] c);
        pixel_valid = v;
        px          = x;
        py          = y;
        pixel_color = c;
    endtask

    initial begin
        int bad;
        int n;

        rst_n = 1'b0;
        mem_ack = 1'b0;
        shape_done = 1'b0;
        clear_start = 1'b0;
        clear_color = 24'h0;
        apply_stimulus(1'b0, 8'd0, 8'd0, 24'h0);

        vecs[0] = '{1'b1, 8'd10,  8'd20,  24'hFF8040, 1'b1, 15'd3210,  16'hFC08};
        vecs[1] = '{1'b1, 8'd159, 8'd119, 24'h123456, 1'b1, 15'd19199, 16'h11AA};
        vecs[2] = '{1'b1, 8'd160, 8'd5,   24'hFFFFFF, 1'b0, 15'd0,     16'h0000};
        vecs[3] = '{1'b1, 8'd0,   8'd0,   24'hFFFFFF, 1'b1, 15'd0,     16'hFFFF};
        vecs[4] = '{1'b1, 8'd5,   8'd120, 24'hFFFFFF, 1'b0, 15'd0,     16'h0000};
        vecs[5] = '{1'b1, 8'd0,   8'd119, 24'h00FF00, 1'b1, 15'd19040, 16'h07E0};
        vecs[6] = '{1'b1, 8'd159, 8'd0,   24'h0000FF, 1'b1, 15'd159,   16'h001F};
        vecs[7] = '{1'b1, 8'd255, 8'd255, 24'hFFFFFF, 1'b0, 15'd0,     16'h0000};
        vecs[8] = '{1'b0, 8'd10,  8'd10,  24'hFFFFFF, 1'b0, 15'd0,     16'h0000};
        vecs[9] = '{1'b1, 8'd100, 8'd50,  24'h808080, 1'b1, 15'd8100,  16'h8410};

        repeat (3) tick();
        check_output("rst_mem_we", mem_we, 0);
        check_output("rst_mem_addr", mem_addr, 0);
        check_output("rst_mem_wdata", mem_wdata, 0);
        check_output("rst_busy", busy, 0);
        check_output("rst_flush_done", flush_done, 0);
        check_output("rst_overflow", overflow, 0);
        rst_n = 1'b1;
        tick();

        // Latency: pixel sampled at edge N, write request visible after edge N+1.
        mem_ack = 1'b1;
        apply_stimulus(1'b1, 8'd10, 8'd20, 24'hFF8040);
        tick();
        apply_stimulus(1'b0, 8'd0, 8'd0, 24'h0);
        check_output("lat_we_early", mem_we, 0);
        tick();
        check_output("lat_we", mem_we, 1);
        check_output("lat_addr", mem_addr, 15'd3210);
        check_output("lat_data", mem_wdata, 16'hFC08);
        tick();
        check_output("lat_we_drop", mem_we, 0);
        repeat (2) tick();

        for (int i = 0; i < 10; i++) begin
            wlog.delete();
            apply_stimulus(vecs[i].valid, vecs[i].x, vecs[i].y, vecs[i].color);
            tick();
            apply_stimulus(1'b0, 8'd0, 8'd0, 24'h0);
            repeat (5) tick();
            check_output($sformatf("vec%0d_count", i), wlog.size(), vecs[i].exp_write ? 1 : 0);
            if (vecs[i].exp_write && wlog.size() > 0) begin
                check_output($sformatf("vec%0d_addr", i), wlog[0].addr, vecs[i].exp_addr);
                check_output($sformatf("vec%0d_data", i), wlog[0].data, vecs[i].exp_data);
            end
        end
        check_output("vec_overflow", overflow, 0);
        check_output("vec_busy", busy, 0);

        // Burst of 20 with ack high: one write per cycle, in order.
        wlog.delete();
        for (int i = 0; i < 20; i++) begin
            apply_stimulus(1'b1, 8'(i), 8'd3, {8'(i * 8), 8'(i * 4), 8'((31 - i) * 8)});
            tick();
        end
        apply_stimulus(1'b0, 8'd0, 8'd0, 24'h0);
        repeat (6) tick();
        check_output("burst_count", wlog.size(), 20);
        for (int i = 0; i < 20 && i < wlog.size(); i++) begin
            check_output($sformatf("burst%0d_addr", i), wlog[i].addr, 15'(480 + i));
            check_output($sformatf("burst%0d_data", i), wlog[i].data, {5'(i), 6'(i), 5'(31 - i)});
            check_output($sformatf("burst%0d_cyc", i), wlog[i].cyc - wlog[0].cyc, i);
        end
        check_output("burst_overflow", overflow, 0);

        // Ack stalled while 12 pixels arrive: 1 in flight, 8 queued, 3 dropped.
        mem_ack = 1'b0;
        wlog.delete();
        for (int i = 0; i < 12; i++) begin
            apply_stimulus(1'b1, 8'(i), 8'd7, 24'h0);
            tick();
        end
        apply_stimulus(1'b0, 8'd0, 8'd0, 24'h0);
        repeat (3) tick();
        check_output("stall_we", mem_we, 1);
        check_output("stall_addr", mem_addr, 15'd1120);
        check_output("stall_overflow", overflow, 1);
        check_output("stall_busy", busy, 1);
        repeat (3) tick();
        check_output("stall_addr_hold", mem_addr, 15'd1120);
        check_output("stall_count_noack", wlog.size(), 0);
        mem_ack = 1'b1;
        repeat (15) tick();
        check_output("stall_written", wlog.size(), 9);
        for (int i = 0; i < 9 && i < wlog.size(); i++)
            check_output($sformatf("stall%0d_addr", i), wlog[i].addr, 15'(1120 + i));
        check_output("stall_overflow_sticky", overflow, 1);

        // Two shape_done edges before the queue drains merge into one pulse.
        wlog.delete();
        pulses = 0;
        pulse_cyc = -1;
        apply_stimulus(1'b1, 8'd1, 8'd2, 24'h0);
        shape_done = 1'b1;
        tick();
        apply_stimulus(1'b1, 8'd2, 8'd2, 24'h0);
        shape_done = 1'b0;
        tick();
        apply_stimulus(1'b1, 8'd3, 8'd2, 24'h0);
        shape_done = 1'b1;
        tick();
        apply_stimulus(1'b0, 8'd0, 8'd0, 24'h0);
        shape_done = 1'b0;
        repeat (8) tick();
        check_output("flush_writes", wlog.size(), 3);
        check_output("flush_pulses", pulses, 1);
        if (wlog.size() == 3)
            check_output("flush_timing", pulse_cyc - wlog[2].cyc, 1);

        // Clear requested while two pixels are outstanding; pixels land first.
        mem_ack = 1'b0;
        wlog.delete();
        apply_stimulus(1'b1, 8'd1, 8'd1, 24'hFFFFFF);
        tick();
        apply_stimulus(1'b1, 8'd2, 8'd1, 24'hFFFFFF);
        tick();
        apply_stimulus(1'b0, 8'd0, 8'd0, 24'h0);
        clear_color = 24'h000000;
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        clear_color = 24'hFFFFFF;
        repeat (2) tick();
        check_output("clr_busy_pending", busy, 1);
        check_output("clr_overflow_before", overflow, 1);
        mem_ack = 1'b1;
        n = 0;
        while (busy && n < 25000) begin
            tick();
            n++;
        end
        check_output("clr_timeout", busy, 0);
        check_output("clr_count", wlog.size(), 19202);
        if (wlog.size() >= 2) begin
            check_output("clr_px0_addr", wlog[0].addr, 15'd161);
            check_output("clr_px0_data", wlog[0].data, 16'hFFFF);
            check_output("clr_px1_addr", wlog[1].addr, 15'd162);
            check_output("clr_px1_data", wlog[1].data, 16'hFFFF);
        end
        bad = 0;
        for (int k = 0; k < 19200 && (k + 2) < wlog.size(); k++)
            if (wlog[k + 2].addr != 15'(k) || wlog[k + 2].data != 16'h0000) bad++;
        check_output("clr_sequence_bad", bad, 0);
        if (wlog.size() == 19202)
            check_output("clr_consecutive", wlog[19201].cyc - wlog[2].cyc, 19199);
        check_output("clr_overflow_cleared", overflow, 0);
        check_output("clr_we_done", mem_we, 0);

        // Asynchronous reset in the middle of a clear.
        clear_color = 24'hFFFFFF;
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        repeat (50) tick();
        check_output("rclr_we", mem_we, 1);
        check_output("rclr_busy", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("rclr_we_async", mem_we, 0);
        check_output("rclr_addr_async", mem_addr, 0);
        check_output("rclr_data_async", mem_wdata, 0);
        check_output("rclr_busy_async", busy, 0);
        check_output("rclr_flush_async", flush_done, 0);
        check_output("rclr_overflow_async", overflow, 0);
        tick();
        rst_n = 1'b1;
        wlog.delete();
        repeat (10) tick();
        check_output("rclr_no_writes", wlog.size(), 0);
        check_output("rclr_busy_after", busy, 0);
        check_output("rclr_we_after", mem_we, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pixel_fb_writer.md
# pixel_fb_writer

Consumes the pixel stream produced by the shape rasterisers (`pixel_valid`/`px`/`py`/`pixel_color`) and commits each pixel into the framebuffer memory. It buffers bursts in a small FIFO and clips off-screen pixels. It converts RGB888 to RGB565, computes linear addresses and drives a request/acknowledge write port. It also performs a full-screen clear and signals when a finished shape has fully landed in memory.

## Interface
- `FB_W`, 160, framebuffer width in pixels (≤256)
- `FB_H`, 120, framebuffer height in pixels (≤256)
- `ADDR_W`, 15, memory address width; must satisfy 2^ADDR_W ≥ FB_W*FB_H
- `FIFO_DEPTH`, 8, pixel FIFO entries; power of two, ≥2

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `pixel_valid`  in  1  pixel present this cycle
- `px`, `py`  in  8 each  pixel coordinates
- `pixel_color`  in  24  RGB888, {R,G,B}
- `shape_done`  in  1  rasteriser done; rising edge requests a flush notification
- `clear_start`  in  1  rising edge requests a full-screen clear
- `clear_color`  in  24  RGB888 clear colour, sampled on the `clear_start` rising edge
- `mem_we`  out  1  write request
- `mem_addr`  out  ADDR_W  linear address, py*FB_W+px
- `mem_wdata`  out  16  RGB565, {c[23:19], c[15:10], c[7:3]}
- `mem_ack`  in  1  memory accepted the write this cycle
- `busy`  out  1  work pending or in progress
- `flush_done`  out  1  one-cycle pulse: every pixel accepted before the `shape_done` edge is written
- `overflow`  out  1  sticky; an in-range pixel was dropped because the FIFO was full

## Operation
- Input acceptance (every cycle, independent of state):
  - A pixel is pushed when `pixel_valid`=1, `px`<FB_W and `py`<FB_H.
  - Out-of-range pixels are silently discarded and do not set `overflow`.
  - If the FIFO is full, the in-range pixel is dropped and `overflow` is set.
  - A push and a pop in the same cycle on a full FIFO are both legal; the push succeeds.
- The FIFO stores the computed address and the RGB565 value. Arithmetic is unsigned, width ADDR_W.
- States:
  - IDLE:
    - If a clear is pending and the FIFO is empty → CLEAR.
    - Else if the FIFO is non-empty → pop an entry, load `mem_addr`/`mem_wdata`, assert `mem_we` → WRITE.
  - WRITE:
    - Hold `mem_we`, `mem_addr` and `mem_wdata` stable until `mem_ack`=1.
    - On ack with the FIFO non-empty and no clear pending: pop the next entry and stay in WRITE (back-to-back).
    - Otherwise: drop `mem_we` → IDLE.
  - CLEAR:
    - Entry clears `overflow`.
    - Write `clear_color` (as RGB565) to addresses 0..FB_W*FB_H-1 in order, with the same ack rule.
    - After the ack of the last address → IDLE.
    - Pixels arriving during CLEAR are enqueued and written after the clear.
- Clear request:
  - The `clear_start` rising edge latches clear-pending and `clear_color`.
  - A pending clear takes priority over the FIFO only once the FIFO drains. Pixels queued before the clear are written first.
  - A `clear_start` edge during CLEAR is ignored.
- Flush:
  - The `shape_done` rising edge sets flush-pending.
  - `flush_done` pulses when flush-pending=1, the FIFO is empty, state is IDLE, and no clear is pending. This clears flush-pending.
  - Repeated edges while pending merge into one pulse.
- `busy` = (state≠IDLE) | FIFO non-empty | clear-pending.

## Timing
- Reset values: `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `busy`=0, `flush_done`=0, `overflow`=0. FIFO empty, all pending flags 0, state IDLE.
- Asserting `rst_n` low mid-write drops `mem_we` immediately; the outstanding write is abandoned.
- Latency: a pixel sampled at edge N (FIFO empty, IDLE) gives `mem_we`=1 in the cycle after edge N+1.
- Throughput with `mem_ack` held high: one write per cycle.
- While waiting for ack, `mem_addr`/`mem_wdata` must not change.
- `flush_done` asserts at the earliest one cycle after the final ack.
- Clear of the default 160×120 with `mem_ack` high: 19200 consecutive write cycles.

## Test plan
- Single pixel (10,20), colour 0xFF8040, `mem_ack`=1 → one write, `mem_addr`=3210, `mem_wdata`=0xFC08, two cycles after the input.
- Pixels (159,119) and (160,5) → only address 19199 written; `overflow`=0.
- 20 consecutive in-range pixels with `mem_ack`=1 → 20 writes on consecutive cycles, in order, no overflow.
- `mem_ack` held 0 while 12 pixels arrive → the first pixel is in WRITE, 8 are queued, the rest are dropped and `overflow`=1. Releasing ack writes exactly 9 pixels.
- 3 pixels, then `shape_done` edge → `flush_done` pulses once, exactly one cycle after the third ack.
- `clear_start` with `clear_color`=0x000000 while 2 pixels are queued → the 2 pixels are written, then 19200 writes of 0x0000; `overflow` is cleared.
- Reset pulse mid-clear → all outputs 0 asynchronously; after release, IDLE with `busy`=0 and no writes.
